seq_adder_n_bits: RTL and testbench

Parametrised multi-cycle adder/subtractor and the sequential successor to the 4-bit ripple full adder. It adds WIDTH-bit operands CHUNK bits per clock, using a CHUNK-bit ripple adder and a registered carry. A valid/ready handshake on both input and output lets it sit between registered producer and consumer stages. It also provides subtract mode, carry-out and signed overflow flags.

---
 rtl/seq_adder_n_bits.sv | 106 ++++++++++
 tb/tb_seq_adder_n_bits.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_n_bits.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock
// through a CHUNK-bit ripple adder with a registered carry, valid/ready on both sides.
module seq_adder_n_bits #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N       = WIDTH / CHUNK;
   localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q;
   logic [IdxW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] chunk_sum_d;
   logic [CHUNK:0]   rc;

   // Ripple carry chain over the current chunk; rc[CHUNK-1] is the carry into its top bit.
   always_comb begin
      slice_a     = op_a_q[idx_q*CHUNK +: CHUNK];
      slice_b     = op_b_q[idx_q*CHUNK +: CHUNK];
      chunk_sum_d = '0;
      rc          = '0;
      rc[0]       = carry_q;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_sum_d[i] = slice_a[i] ^ slice_b[i] ^ rc[i];
         rc[i+1]        = (slice_a[i] & slice_b[i]) | (rc[i] & (slice_a[i] ^ slice_b[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op_a_q  <= a;
                  op_b_q  <= sub ? ~b : b;
                  carry_q <= sub | cin;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum_d;
               carry_q <= rc[CHUNK];
               idx_q   <= idx_q + IdxW'(1);
               if (idx_q == LastIdx) begin
                  idx_q   <= '0;
                  cout_q  <= rc[CHUNK];
                  ovf_q   <= rc[CHUNK] ^ rc[CHUNK-1];
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_adder_n_bits.sv
// Bench for seq_adder_n_bits: 16/4 directed + random ops, and exhaustive WIDTH=4
// runs for CHUNK=1,2,4, all checked against an integer-arithmetic reference model.
module tb_seq_adder_n_bits;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [15:0] a = '0, b = '0, sum;
   logic        cin = 1'b0, sub = 1'b0, cout, ovf;

   seq_adder_n_bits #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   logic [2:0]      s_in_valid = '0, s_in_ready, s_out_valid, s_out_ready = '0;
   logic [2:0]      s_cin = '0, s_sub = '0, s_cout, s_ovf;
   logic [2:0][3:0] s_a = '0, s_b = '0, s_sum;

   for (genvar k = 0; k < 3; k++) begin : g_small
      seq_adder_n_bits #(.WIDTH(4), .CHUNK((k == 0) ? 1 : (k == 1) ? 2 : 4)) u_small (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (s_in_valid[k]),
         .in_ready  (s_in_ready[k]),
         .a         (s_a[k]),
         .b         (s_b[k]),
         .cin       (s_cin[k]),
         .sub       (s_sub[k]),
         .out_valid (s_out_valid[k]),
         .out_ready (s_out_ready[k]),
         .sum       (s_sum[k]),
         .cout      (s_cout[k]),
         .ovf       (s_ovf[k])
      );
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, signed overflow as out-of-range result.
   function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv,
                                 output logic [15:0] es, output logic ec, output logic eo);
      longint ua, ub, full, sa, sb, s, lim, m;
      m   = longint'(1) << w;
      lim = longint'(1) << (w - 1);
      ua  = longint'(av);
      ub  = longint'(bv);
      if (sv) begin
         full = ua - ub;
         if (full < 0) full += m;
         ec = (ua >= ub);
      end else begin
         full = ua + ub + longint'(cv);
         ec   = (full >= m);
         full = full % m;
      end
      es = 16'(full);
      sa = (ua >= lim) ? ua - m : ua;
      sb = (ub >= lim) ? ub - m : ub;
      s  = sv ? sa - sb : sa + sb + longint'(cv);
      eo = (s >= lim) || (s < -lim);
   endfunction

   // Called #1 after a rising edge (or on a falling edge) with the DUT idle.
   task automatic op16(input logic [15:0] a_v, input logic [15:0] b_v, input logic cin_v,
                       input logic sub_v, input bit release_out);
      logic [15:0] es;
      logic        ec, eo;
      int          lat;
      model(16, a_v, b_v, cin_v, sub_v, es, ec, eo);
      check("in_ready_idle", 32'(in_ready), 1);
      a = a_v; b = b_v; cin = cin_v; sub = sub_v; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("lat16", 32'(lat), 4);
      check("sum16", 32'(sum), 32'(es));
      check("cout16", 32'(cout), 32'(ec));
      check("ovf16", 32'(ovf), 32'(eo));
      if (release_out) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         check("done_to_idle16", 32'(in_ready), 1);
      end
   endtask

   task automatic op4(input int k, input logic [3:0] a_v, input logic [3:0] b_v,
                      input logic cin_v, input logic sub_v);
      logic [15:0] es;
      logic        ec, eo;
      int          lat, exp_lat;
      exp_lat = (k == 0) ? 4 : (k == 1) ? 2 : 1;
      model(4, 16'(a_v), 16'(b_v), cin_v, sub_v, es, ec, eo);
      check("in_ready_idle4", 32'(s_in_ready[k]), 1);
      s_a[k] = a_v; s_b[k] = b_v; s_cin[k] = cin_v; s_sub[k] = sub_v; s_in_valid[k] = 1'b1;
      @(posedge clk);
      #1;
      s_in_valid[k] = 1'b0;
      s_a[k] = ~a_v; s_b[k] = ~b_v;
      lat = 0;
      while (!s_out_valid[k] && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("lat4", 32'(lat), 32'(exp_lat));
      check("sum4", 32'(s_sum[k]), 32'(es[3:0]));
      check("cout4", 32'(s_cout[k]), 32'(ec));
      check("ovf4", 32'(s_ovf[k]), 32'(eo));
      s_out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      s_out_ready[k] = 1'b0;
   endtask

   initial begin
      bit seen;
      #12;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_cout", 32'(cout), 0);
      check("rst_ovf", 32'(ovf), 0);

      // Release on a falling edge; the very next rising edge accepts.
      @(negedge clk);
      rst_n = 1'b1;
      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      op16(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);

      // Backpressure with new operands offered while DONE.
      op16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      repeat (3) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         @(posedge clk);
         #1;
         check("bp_sum", 32'(sum), 32'h5555);
         check("bp_cout", 32'(cout), 0);
         check("bp_ovf", 32'(ovf), 0);
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_out_valid", 32'(out_valid), 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release_in_ready", 32'(in_ready), 1);
      check("bp_release_out_valid", 32'(out_valid), 0);
      @(posedge clk);
      #1;
      check("idle_hold_sum", 32'(sum), 32'h5555);
      check("idle_no_accept", 32'(out_valid), 0);

      // Reset after two BUSY edges.
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_in_ready", 32'(in_ready), 1);
      check("mid_rst_sum", 32'(sum), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("mid_rst_no_result", 32'(seen), 0);

      repeat (40) begin
         op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end

      for (int k = 0; k < 3; k++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               op4(k, 4'(x), 4'(y), 1'b0, 1'b0);
               op4(k, 4'(x), 4'(y), 1'b1, 1'b0);
               op4(k, 4'(x), 4'(y), 1'($urandom), 1'b1);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
